// File: rtl/serial_tx_if.sv
// Word handshake into the serial transmitter: producer drives data/valid, transmitter drives ready.
interface serial_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/serial_tx.sv
// Parallel-in serial-out transmitter: start bit, data LSB-first, optional even parity, stop bit.
// Every line bit is held for CLKS_PER_BIT cycles; tx comes straight from a flop.
module serial_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    serial_tx_if.slave in_if,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               parity_q, parity_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               bit_end;

    assign in_if.in_ready = (state_q == StIdle) && !reset;
    assign tx             = tx_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        bit_end  = (cnt_q == CNT_LAST);

        // Cycle counter restarts at every bit boundary, so each phase starts from zero.
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (in_if.in_valid) begin
                    state_d  = StStart;
                    shreg_d  = in_if.in_data;
                    parity_d = ^in_if.in_data;
                    cnt_d    = '0;
                    idx_d    = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Line value is decoded from the upcoming state so tx lines up with the phase.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (4 clk/bit, 4 clk/bit with parity, 1 clk/bit) checked
// cycle by cycle against a frame built from the bit sequence rules.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_valid;
    logic [7:0] in_data [3];
    logic [2:0] tx_w, busy_w, done_w, rdy_w;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_tx_if #(.WIDTH(8)) bus ();
        assign bus.in_data  = in_data[g];
        assign bus.in_valid = in_valid[g];
        assign rdy_w[g]     = bus.in_ready;

        serial_tx #(
            .WIDTH       (8),
            .CLKS_PER_BIT((g == 2) ? 1 : 4),
            .PARITY_EN   ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .in_if(bus.slave),
            .tx   (tx_w[g]),
            .busy (busy_w[g]),
            .done (done_w[g])
        );
    end

    function automatic int cpb_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit par_of(input int k);
        return (k == 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at an idle negedge; leaves the bench at cycle 1 after the accept edge.
    task automatic accept(input int k, input logic [7:0] w);
        check_eq("ready_idle", 32'(rdy_w[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = w;
        step();
    endtask

    // Checks a whole frame; with hold set, nxt is offered throughout and taken on the done cycle.
    task automatic frame(input int k, input logic [7:0] w, input bit hold, input logic [7:0] nxt);
        bit bits[$];
        int cpb;
        cpb = cpb_of(k);
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(w[b]);
        if (par_of(k)) bits.push_back(($countones(w) % 2) == 1);
        bits.push_back(1'b1);
        in_valid[k] = hold;
        for (int i = 0; i < bits.size() * cpb; i++) begin
            check_eq("tx", 32'(tx_w[k]), 32'(bits[i / cpb]));
            check_eq("busy", 32'(busy_w[k]), 32'd1);
            check_eq("done_early", 32'(done_w[k]), 32'd0);
            check_eq("ready_busy", 32'(rdy_w[k]), 32'd0);
            in_data[k] = hold ? nxt : 8'($urandom);
            step();
        end
        check_eq("done_pulse", 32'(done_w[k]), 32'd1);
        check_eq("busy_done", 32'(busy_w[k]), 32'd0);
        check_eq("tx_idle", 32'(tx_w[k]), 32'd1);
        check_eq("ready_done", 32'(rdy_w[k]), 32'd1);
        step();
        if (!hold) begin
            check_eq("done_one_cycle", 32'(done_w[k]), 32'd0);
            check_eq("busy_after", 32'(busy_w[k]), 32'd0);
        end
    endtask

    initial begin
        int         k;
        logic [7:0] w, w2;
        bit         hold;

        reset    = 1'b1;
        in_valid = 3'b111;
        for (int j = 0; j < 3; j++) in_data[j] = 8'($urandom);
        for (int c = 0; c < 2; c++) begin
            step();
            for (int j = 0; j < 3; j++) begin
                check_eq("rst_tx", 32'(tx_w[j]), 32'd1);
                check_eq("rst_busy", 32'(busy_w[j]), 32'd0);
                check_eq("rst_done", 32'(done_w[j]), 32'd0);
                check_eq("rst_ready", 32'(rdy_w[j]), 32'd0);
            end
        end
        reset    = 1'b0;
        in_valid = 3'b000;
        step();

        accept(0, 8'hA5);
        frame(0, 8'hA5, 1'b0, 8'h00);

        accept(1, 8'hA5);
        frame(1, 8'hA5, 1'b0, 8'h00);
        accept(1, 8'h07);
        frame(1, 8'h07, 1'b0, 8'h00);

        accept(0, 8'h00);
        frame(0, 8'h00, 1'b1, 8'hFF);
        frame(0, 8'hFF, 1'b0, 8'h00);

        // Abort during data bit 3 (cycles 17..20 after accept).
        accept(0, 8'h3C);
        in_valid[0] = 1'b0;
        repeat (17) step();
        check_eq("pre_abort_busy", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check_eq("abort_tx", 32'(tx_w[0]), 32'd1);
            check_eq("abort_busy", 32'(busy_w[0]), 32'd0);
            check_eq("abort_done", 32'(done_w[0]), 32'd0);
            step();
        end
        accept(0, 8'h81);
        frame(0, 8'h81, 1'b0, 8'h00);

        accept(2, 8'h01);
        frame(2, 8'h01, 1'b0, 8'h00);

        for (int r = 0; r < 24; r++) begin
            k    = $urandom_range(0, 2);
            w    = 8'($urandom);
            w2   = 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
            accept(k, w);
            frame(k, w, hold, w2);
            if (hold) frame(k, w2, 1'b0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
